// File: rtl/npu_seq.sv
// npu_seq: NPU-side sequencer for the CPU matrix-multiply / convolution handshake.
// Enumerates the operand terms of C = A x B (DIM x DIM, row-major) or of a 1-D
// convolution Y[n] = sum_t X[n+t]*W[t]. It drives the operand read addresses,
// feeds the returned data through a one-deep tag pipeline into a wrapping MAC,
// and writes one result per output group. The completion pulse and busy flag
// are registered copies of the sequencer state.
module npu_seq #(
    parameter int DIM      = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 64,
    parameter int CONV_LEN = 16,
    parameter int KLEN     = 3,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_matrix_mul,
    input  logic              start_conv,
    output logic              done,
    output logic              busy,
    output logic              op_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [ACC_W-1:0]  res_wdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] DIM_A  = ADDR_W'(DIM);
    localparam logic [ADDR_W-1:0] LIM_D  = ADDR_W'(DIM - 1);
    localparam logic [ADDR_W-1:0] LIM_K  = ADDR_W'(KLEN - 1);
    localparam logic [ADDR_W-1:0] LIM_N  = ADDR_W'(CONV_LEN - KLEN);

    // Signed DATA_W x DATA_W product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mac_prod(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        return ACC_W'(p);
    endfunction

    // Control state
    state_t              state_q, state_d;
    logic                conv_q, conv_d;       // 1 = convolution, 0 = matrix multiply
    logic [ADDR_W-1:0]   outer_q, outer_d;     // MAT: i   CONV: n
    logic [ADDR_W-1:0]   mid_q, mid_d;         // MAT: j   CONV: unused (0)
    logic [ADDR_W-1:0]   inner_q, inner_d;     // MAT: k   CONV: t
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Tag pipeline (issue -> data return) and MAC / result registers
    logic                vld_p1_q, vld_p1_d;
    logic                last_p1_q, last_p1_d;
    logic [ADDR_W-1:0]   waddr_p1_q, waddr_p1_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                res_we_q, res_we_d;
    logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
    logic [ACC_W-1:0]    res_wdata_q, res_wdata_d;

    // Combinational helpers
    logic                issue;
    logic                inner_end;
    logic                mid_end;
    logic                outer_end;
    logic                last_term;
    logic [ADDR_W-1:0]   grp_addr;
    logic signed [DATA_W-1:0] a_op;
    logic signed [DATA_W-1:0] b_op;
    logic signed [ACC_W-1:0]  prod;

    // Loop-end detection; the middle loop only exists in matrix mode.
    always_comb begin
        issue     = (state_q == S_RUN);
        inner_end = (inner_q == (conv_q ? LIM_K : LIM_D));
        mid_end   = conv_q | (mid_q == LIM_D);
        outer_end = (outer_q == (conv_q ? LIM_N : LIM_D));
        last_term = inner_end & mid_end & outer_end;
    end

    // Operand and result addresses from the term counters; zero outside RUN.
    always_comb begin
        a_addr   = '0;
        b_addr   = '0;
        grp_addr = '0;
        if (issue) begin
            if (conv_q) begin
                a_addr   = outer_q + inner_q;
                b_addr   = inner_q;
                grp_addr = outer_q;
            end else begin
                a_addr   = outer_q * DIM_A + inner_q;
                b_addr   = inner_q * DIM_A + mid_q;
                grp_addr = outer_q * DIM_A + mid_q;
            end
        end
    end

    // Sequencer FSM: request arbitration, term counting, drain and completion.
    always_comb begin
        state_d  = state_q;
        conv_d   = conv_q;
        outer_d  = outer_q;
        mid_d    = mid_q;
        inner_d  = inner_q;
        op_rd_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_matrix_mul) begin
                    state_d = S_RUN;
                    conv_d  = 1'b0;
                    outer_d = '0;
                    mid_d   = '0;
                    inner_d = '0;
                end else if (start_conv) begin
                    state_d = S_RUN;
                    conv_d  = 1'b1;
                    outer_d = '0;
                    mid_d   = '0;
                    inner_d = '0;
                end
            end
            S_RUN: begin
                op_rd_en = 1'b1;
                inner_d  = inner_end ? '0 : inner_q + ONE_A;
                if (inner_end) begin
                    if (mid_end) begin
                        mid_d   = '0;
                        outer_d = outer_q + ONE_A;
                    end else begin
                        mid_d   = mid_q + ONE_A;
                    end
                end
                if (last_term) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_q != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // MAC stage: operands are only looked at when the tag says they are valid.
    always_comb begin
        vld_p1_d    = issue;
        last_p1_d   = issue & inner_end;
        waddr_p1_d  = grp_addr;
        a_op        = vld_p1_q ? signed'(a_rdata) : '0;
        b_op        = vld_p1_q ? signed'(b_rdata) : '0;
        prod        = mac_prod(a_op, b_op);
        acc_d       = acc_q;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_wdata_d = res_wdata_q;
        if (vld_p1_q) begin
            if (last_p1_q) begin
                res_we_d    = 1'b1;
                res_addr_d  = waddr_p1_q;
                res_wdata_d = acc_q + prod;
                acc_d       = '0;
            end else begin
                acc_d       = acc_q + prod;
            end
        end
    end

    // State, pipeline and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            conv_q      <= 1'b0;
            outer_q     <= '0;
            mid_q       <= '0;
            inner_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_p1_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            waddr_p1_q  <= '0;
            acc_q       <= '0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            conv_q      <= conv_d;
            outer_q     <= outer_d;
            mid_q       <= mid_d;
            inner_q     <= inner_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_p1_q    <= vld_p1_d;
            last_p1_q   <= last_p1_d;
            waddr_p1_q  <= waddr_p1_d;
            acc_q       <= acc_d;
            res_we_q    <= res_we_d;
            res_addr_q  <= res_addr_d;
            res_wdata_q <= res_wdata_d;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign res_we    = res_we_q;
    assign res_addr  = res_addr_q;
    assign res_wdata = res_wdata_q;

endmodule

// File: tb/tb_npu_seq.sv
// tb_npu_seq: directed bench for npu_seq with operand memories, a result
// recorder and hand-computed expectations.
module tb_npu_seq;

    localparam int DIM = 4, DATA_W = 16, ACC_W = 64, CONV_LEN = 16, KLEN = 3, ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_matrix_mul = 1'b0;
    logic              start_conv = 1'b0;
    logic              done, busy, op_rd_en, res_we;
    logic [ADDR_W-1:0] a_addr, b_addr, res_addr;
    logic [DATA_W-1:0] a_rdata = '0, b_rdata = '0;
    logic [ACC_W-1:0]  res_wdata;

    npu_seq #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .CONV_LEN(CONV_LEN),
              .KLEN(KLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_matrix_mul(start_matrix_mul), .start_conv(start_conv),
        .done(done), .busy(busy), .op_rd_en(op_rd_en),
        .a_addr(a_addr), .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
        .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] a_mem [256];
    logic [DATA_W-1:0] b_mem [256];

    // Operand buffers with one-cycle read latency
    always @(posedge clk) begin
        if (op_rd_en) begin
            a_rdata <= a_mem[a_addr];
            b_rdata <= b_mem[b_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Recorder sampling on the falling edge
    logic [ADDR_W-1:0] wa [512];
    logic [ACC_W-1:0]  wd [512];
    int nw = 0, ndone = 0, nbusy = 0, nrd = 0, last_done_cyc = -1;
    always @(negedge clk) begin
        if (res_we && nw < 512) begin
            wa[nw] <= res_addr;
            wd[nw] <= res_wdata;
            nw     <= nw + 1;
        end
        if (done) begin
            ndone         <= ndone + 1;
            last_done_cyc <= cyc;
        end
        if (busy)     nbusy <= nbusy + 1;
        if (op_rd_en) nrd   <= nrd + 1;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int e0;
    task automatic start_op(input bit mm, input bit cv);
        @(negedge clk);
        start_matrix_mul = mm;
        start_conv       = cv;
        @(posedge clk);
        #1 e0 = cyc;
    endtask

    // Wait for done, dropping the held request(s) while done is high.
    task automatic wait_done(input int maxc, input bit drop_cv, output int dc);
        dc = -1;
        for (int k = 0; k < maxc; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dc = cyc;
                start_matrix_mul = 1'b0;
                if (drop_cv) start_conv = 1'b0;
                break;
            end
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int dc, dc2, w0, d0, b0, r0, e0b;

    initial begin
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end

        // ---------------- reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_we", res_we, 0);
        chk("rst_op_rd_en", op_rd_en, 0);
        chk("rst_res_wdata", res_wdata, 0);
        @(negedge clk) rst_n = 1'b1;
        settle(2);

        // ---------------- MAT identity: A = I, B[r] = r
        for (int r = 0; r < 16; r++) begin
            a_mem[r] = ((r / 4) == (r % 4)) ? 16'd1 : 16'd0;
            b_mem[r] = 16'(r);
        end
        w0 = nw; d0 = ndone; b0 = nbusy; r0 = nrd;
        start_op(1'b1, 1'b0);
        wait_done(200, 1'b0, dc);
        chk("mat_done_cycle", dc, e0 + 66);
        settle(1);
        chk("mat_done_width", done, 0);
        settle(2);
        chk("mat_writes", nw - w0, 16);
        chk("mat_dones", ndone - d0, 1);
        chk("mat_busy_cycles", nbusy - b0, 66);
        chk("mat_reads", nrd - r0, 64);
        for (int r = 0; r < 16; r++) begin
            chk("mat_addr", wa[w0 + r], r);
            chk("mat_data", wd[w0 + r], r);
        end

        // ---------------- CONV: X[n] = n+1, W = {1,2,3} -> Y[n] = 6n+14
        for (int n = 0; n < 16; n++) a_mem[n] = 16'(n + 1);
        b_mem[0] = 16'd1; b_mem[1] = 16'd2; b_mem[2] = 16'd3;
        w0 = nw; d0 = ndone; b0 = nbusy; r0 = nrd;
        start_op(1'b0, 1'b1);
        wait_done(200, 1'b1, dc);
        chk("conv_done_cycle", dc, e0 + 44);
        settle(3);
        chk("conv_writes", nw - w0, 14);
        chk("conv_dones", ndone - d0, 1);
        chk("conv_busy_cycles", nbusy - b0, 44);
        chk("conv_reads", nrd - r0, 42);
        chk("conv_busy_after", busy, 0);
        for (int n = 0; n < 14; n++) begin
            chk("conv_addr", wa[w0 + n], n);
            chk("conv_data", wd[w0 + n], 64'(6 * n + 14));
        end

        // ---------------- signed extremes: -32768 * -32768 * 4 = 2^32
        for (int r = 0; r < 16; r++) begin
            a_mem[r] = 16'h8000;
            b_mem[r] = 16'h8000;
        end
        w0 = nw;
        start_op(1'b1, 1'b0);
        wait_done(200, 1'b0, dc);
        settle(3);
        chk("neg_writes", nw - w0, 16);
        for (int r = 0; r < 16; r++) chk("neg_data", wd[w0 + r], 64'h0000_0001_0000_0000);

        // ---------------- -1 * 1 summed over 4 terms = -4
        for (int r = 0; r < 16; r++) begin
            a_mem[r] = 16'hFFFF;
            b_mem[r] = 16'h0001;
        end
        w0 = nw;
        start_op(1'b1, 1'b0);
        wait_done(200, 1'b0, dc);
        settle(3);
        chk("m1_writes", nw - w0, 16);
        for (int r = 0; r < 16; r++) chk("m1_data", wd[w0 + r], 64'hFFFF_FFFF_FFFF_FFFC);

        // ---------------- simultaneous starts: MAT first, then the held CONV
        for (int r = 0; r < 16; r++) begin
            a_mem[r] = 16'd1;
            b_mem[r] = 16'd1;
        end
        w0 = nw; d0 = ndone; r0 = nrd;
        start_op(1'b1, 1'b1);
        wait_done(200, 1'b0, dc);
        chk("sim_mat_done_cycle", dc, e0 + 66);
        wait_done(200, 1'b1, dc2);
        chk("sim_conv_done_cycle", dc2, e0 + 67 + 44);
        settle(3);
        chk("sim_writes", nw - w0, 30);
        chk("sim_dones", ndone - d0, 2);
        chk("sim_reads", nrd - r0, 106);
        for (int r = 0; r < 16; r++) begin
            chk("sim_mat_addr", wa[w0 + r], r);
            chk("sim_mat_data", wd[w0 + r], 4);
        end
        for (int n = 0; n < 14; n++) begin
            chk("sim_conv_addr", wa[w0 + 16 + n], n);
            chk("sim_conv_data", wd[w0 + 16 + n], 3);
        end

        // ---------------- back-to-back CONV
        for (int n = 0; n < 16; n++) a_mem[n] = 16'(n + 1);
        b_mem[0] = 16'd1; b_mem[1] = 16'd2; b_mem[2] = 16'd3;
        w0 = nw; d0 = ndone;
        start_op(1'b0, 1'b1);
        wait_done(200, 1'b1, dc);
        chk("b2b_first_done", dc, e0 + 44);
        settle(1);
        start_conv = 1'b1;
        e0b = dc + 2;
        wait_done(200, 1'b1, dc2);
        chk("b2b_second_done", dc2, e0b + 44);
        settle(3);
        chk("b2b_writes", nw - w0, 28);
        chk("b2b_dones", ndone - d0, 2);
        for (int q = 0; q < 28; q++) begin
            chk("b2b_addr", wa[w0 + q], q % 14);
            chk("b2b_data", wd[w0 + q], 64'(6 * (q % 14) + 14));
        end

        // ---------------- reset mid-operation
        w0 = nw; d0 = ndone;
        start_op(1'b1, 1'b0);
        settle(20);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res_we", res_we, 0);
        chk("abort_op_rd_en", op_rd_en, 0);
        chk("abort_a_addr", a_addr, 0);
        chk("abort_b_addr", b_addr, 0);
        chk("abort_res_addr", res_addr, 0);
        chk("abort_res_wdata", res_wdata, 0);
        start_matrix_mul = 1'b0;
        @(negedge clk);
        chk("abort_writes_before", nw - w0, 4);
        w0 = nw;
        settle(3);
        @(negedge clk) rst_n = 1'b1;
        settle(6);
        chk("abort_no_writes", nw - w0, 0);
        chk("abort_no_done", ndone - d0, 0);
        start_op(1'b0, 1'b1);
        wait_done(200, 1'b1, dc);
        chk("post_rst_done_cycle", dc, e0 + 44);
        settle(3);
        chk("post_rst_writes", nw - w0, 14);
        chk("post_rst_dones", ndone - d0, 1);
        chk("post_rst_first", wd[w0], 14);
        chk("post_rst_last", wd[w0 + 13], 92);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
